muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: EX-stage request, valid for one cycle.
REQ-004 SHALL have port funct, input, selector::muldiv_funct_t: MULDIV_MULT / MULTU / DIV / DIVU / NCARE.
REQ-005 SHALL have port a, input, 32 bits: rs operand (multiplicand or dividend).
REQ-006 SHALL have port b, input, 32 bits: rt operand (multiplier or divisor).
REQ-007 SHALL have port flush, input, 1 bit: cancel the in-flight operation (exception or pipeline flush).
REQ-008 SHALL have port busy, output, 1 bit: an operation is in progress; the pipeline stalls MFHI/MFLO/MTHI/MTLO and the next muldiv op on it.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse; hi/lo valid, and the HI/LO file writes both.
REQ-010 SHALL have port hi, output, 32 bits: product[63:32] or remainder.
REQ-011 SHALL have port lo, output, 32 bits: product[31:0] or quotient.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, FIXUP, DONE.
REQ-013 In IDLE or DONE, start with funct other than NCARE SHALL latch a, b and funct, and go to RUN; start with NCARE SHALL be ignored.
REQ-014 With no accepted start, DONE SHALL return to IDLE.
REQ-015 RUN SHALL last exactly 32 cycles, counted by a 5-bit iteration counter (0..31, no wrap), one radix-2 step per cycle.
REQ-016 Multiply SHALL use shift-add on operand magnitudes into a 64-bit accumulator.
REQ-017 Divide SHALL use restoring shift-subtract on magnitudes: 32-bit remainder, 33-bit trial subtract.
REQ-018 The magnitude of an operand SHALL be its two's-complement absolute value for MULT/DIV; operands SHALL be taken unchanged for MULTU/DIVU.
REQ-019 FIXUP SHALL last one cycle and apply sign correction:
- MULT: negate the 64-bit product iff sign(a) differs from sign(b).
- DIV: negate the quotient iff the signs differ; negate the remainder iff a is negative.
REQ-020 DONE SHALL last one cycle with done=1; hi/lo SHALL hold their value until the next done.
REQ-021 Latency SHALL be fixed: start sampled at edge 0, RUN in cycles 1..32, FIXUP in cycle 33, done=1 in cycle 34.
REQ-022 busy SHALL be 1 in RUN and FIXUP and 0 in IDLE and DONE.
REQ-023 start while busy=1 SHALL be ignored, with no state change.
REQ-024 Divide by zero SHALL give lo=32'hFFFFFFFF and hi=a (DIVU), and the sign-fixed equivalent of that for DIV; no exception.
REQ-025 DIV 32'h80000000 / 32'hFFFFFFFF SHALL give lo=32'h80000000, hi=0.
REQ-026 flush in any state SHALL force IDLE at the next edge with done=0; hi/lo SHALL be unchanged.
REQ-027 When flush and start are high in the same cycle, flush SHALL win and start SHALL be dropped.
REQ-028 When reset and flush are high in the same cycle, reset SHALL win.

Reset
REQ-029 Reset SHALL set state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0 and the internal operand/accumulator registers to 0.
REQ-030 Reset asserted mid-RUN SHALL abort the operation with no done pulse.

Structure
REQ-031 The package selector SHALL hold muldiv_funct_t (existing).
REQ-032 The package signals SHALL hold muldiv_state_t (IDLE, RUN, FIXUP, DONE) and the constant MULDIV_ITERATIONS=32.
REQ-033 The block SHALL have one combinational sub-module, muldiv_step, computing one multiply or divide iteration from accumulator, operand and mode.
REQ-034 The FSM, counter and sign-fixup logic SHALL live in muldiv_sequencer.

Verification
REQ-035 MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> busy high in cycles 1..33; done in cycle 34 with hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-036 MULT a=-3, b=5 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFF1.
REQ-037 DIV a=-7, b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIV 32'h80000000 / 32'hFFFFFFFF -> lo=32'h80000000, hi=0.
REQ-038 DIVU a=100, b=0 -> lo=32'hFFFFFFFF, hi=100, no other side effect.
REQ-039 Flush sequence:
- flush in cycle 10 of a DIVU -> busy=0 from cycle 11, no done.
- A new start in cycle 12 completes correctly in cycle 46.
REQ-040 Start and reset sequence:
- Second start in cycle 5 of a MULT -> ignored; only one done, with the first op's result.
- reset in cycle 20 -> all outputs 0 in the next cycle.

Source files
------------

// File: rtl/selector.sv
// Function-select encoding shared by the decoder and the multiply/divide unit.
package selector;

  typedef enum logic [2:0] {
    MULDIV_MULT,
    MULDIV_MULTU,
    MULDIV_DIV,
    MULDIV_DIVU,
    MULDIV_NCARE
  } muldiv_funct_t;

endpackage

// File: rtl/signals.sv
// Sequencer state encoding, iteration count and operand-magnitude helper.
package signals;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIXUP,
    DONE
  } muldiv_state_t;

  localparam int MULDIV_ITERATIONS = 32;

  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on a {hi,lo} accumulator.
// Purely combinational; accumulator is {product} or {remainder, dividend/quotient}.
module muldiv_step (
  input  logic [63:0] acc_i,
  input  logic [31:0] operand_i,
  input  logic        is_div_i,
  output logic [63:0] acc_o
);

  logic [32:0] add_sum;
  logic [32:0] trial;

  always_comb begin
    add_sum = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, operand_i} : 33'd0);
    // Shifted partial remainder minus divisor; a borrow in bit 32 means restore.
    trial   = acc_i[63:31] - {1'b0, operand_i};
    if (is_div_i) begin
      acc_o = trial[32] ? {acc_i[62:0], 1'b0} : {trial[31:0], acc_i[30:0], 1'b1};
    end else begin
      acc_o = {add_sum, acc_i[31:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU: 32 RUN cycles, 1 FIXUP, done in cycle 34 after start.
// Starts while busy are dropped; flush/reset abort without done, hi/lo hold until next done.
module muldiv_sequencer
  import selector::*;
  import signals::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  muldiv_funct_t funct,
  input  logic [31:0]   a,
  input  logic [31:0]   b,
  input  logic          flush,
  output logic          busy,
  output logic          done,
  output logic [31:0]   hi,
  output logic [31:0]   lo
);

  muldiv_state_t state_q, state_d;
  logic [4:0]    iter_q, iter_d;
  logic [63:0]   acc_q, acc_d, step_acc;
  logic [31:0]   opnd_q, opnd_d;
  logic          is_div_q, is_div_d;
  logic          a_neg_q, a_neg_d;
  logic          b_neg_q, b_neg_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic          op_signed;
  logic [63:0]   prod_fix;
  logic [31:0]   quo_fix, rem_fix;

  muldiv_step u_step (
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .is_div_i  (is_div_q),
    .acc_o     (step_acc)
  );

  // a_neg/b_neg are only ever set for signed ops, so unsigned results pass through.
  always_comb begin
    op_signed = (funct == MULDIV_MULT) || (funct == MULDIV_DIV);
    prod_fix  = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
    quo_fix   = (a_neg_q ^ b_neg_q) ? -acc_q[31:0] : acc_q[31:0];
    rem_fix   = a_neg_q ? -acc_q[63:32] : acc_q[63:32];
  end

  always_comb begin
    state_d  = state_q;
    iter_d   = iter_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start && funct != MULDIV_NCARE) begin
          state_d  = RUN;
          iter_d   = 5'd0;
          is_div_d = (funct == MULDIV_DIV) || (funct == MULDIV_DIVU);
          a_neg_d  = op_signed & a[31];
          b_neg_d  = op_signed & b[31];
          acc_d    = {32'd0, magnitude(a, op_signed)};
          opnd_d   = magnitude(b, op_signed);
        end
      end
      RUN: begin
        acc_d = step_acc;
        if (iter_q == 5'(MULDIV_ITERATIONS - 1)) begin
          state_d = FIXUP;
        end else begin
          iter_d = iter_q + 5'd1;
        end
      end
      FIXUP: begin
        state_d = DONE;
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      iter_q   <= 5'd0;
      acc_q    <= 64'd0;
      opnd_q   <= 32'd0;
      is_div_q <= 1'b0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      iter_q   <= iter_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = (state_q == RUN) || (state_q == FIXUP);
  assign done = (state_q == DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases plus random ops vs an arithmetic model.
module tb_muldiv_sequencer;
  import selector::*;

  logic          clk = 1'b0;
  logic          reset, start, flush;
  muldiv_funct_t funct;
  logic [31:0]   a, b;
  logic          busy, done;
  logic [31:0]   hi, lo;

  int n_chk  = 0;
  int n_fail = 0;

  logic [63:0] last_res;

  muldiv_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .funct (funct),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference result {hi, lo} straight from the architectural definition.
  function automatic logic [63:0] model(input muldiv_funct_t f, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    int     ix, iy;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ix = $signed(x);
    iy = $signed(y);
    r  = 64'd0;
    case (f)
      MULDIV_MULT:  r = 64'(sx * sy);
      MULDIV_MULTU: r = {32'd0, x} * {32'd0, y};
      MULDIV_DIVU:  r = (y == 32'd0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
      MULDIV_DIV: begin
        if (y == 32'd0)
          r = {x, (x[31] ? 32'd1 : 32'hFFFFFFFF)};
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF)
          r = {32'd0, 32'h80000000};
        else
          r = {32'(ix % iy), 32'(ix / iy)};
      end
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  // Called at a negedge with the unit idle; that cycle is cycle 0 of the op.
  task automatic do_op(input muldiv_funct_t f, input logic [31:0] x, input logic [31:0] y, input string tag);
    int lat = 0;
    int busy_bad = 0;
    logic [63:0] exp;
    exp   = model(f, x, y);
    start = 1'b1;
    funct = f;
    a     = x;
    b     = y;
    for (int c = 1; c <= 60 && lat == 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy !== (c <= 33)) busy_bad++;
      if (done === 1'b1) lat = c;
    end
    chk({tag, " latency"}, 64'(lat), 64'd34);
    chk({tag, " busy"}, 64'(busy_bad), 64'd0);
    chk({tag, " result"}, {hi, lo}, exp);
    last_res = {hi, lo};
    @(negedge clk);
    chk({tag, " done_clr"}, {63'd0, done}, 64'd0);
    chk({tag, " hold"}, {hi, lo}, exp);
  endtask

  function automatic logic [31:0] rnd_opnd();
    logic [31:0] sp [6];
    sp = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd2};
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 5)];
    if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 300));
    return $urandom;
  endfunction

  initial begin
    logic [63:0] prev, res;
    int dn, lat;
    reset = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    funct = MULDIV_NCARE;
    a     = 32'd0;
    b     = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset busy_done", {62'd0, busy, done}, 64'd0);
    chk("reset hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    do_op(MULDIV_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
    chk("multu_max const", last_res, 64'hFFFFFFFE_00000001);
    do_op(MULDIV_MULT, 32'hFFFFFFFD, 32'd5, "mult_neg");
    chk("mult_neg const", last_res, 64'hFFFFFFFF_FFFFFFF1);
    do_op(MULDIV_DIV, 32'hFFFFFFF9, 32'd2, "div_neg");
    chk("div_neg const", last_res, 64'hFFFFFFFF_FFFFFFFD);
    do_op(MULDIV_DIV, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    chk("div_ovf const", last_res, 64'h00000000_80000000);
    do_op(MULDIV_DIVU, 32'd100, 32'd0, "divu_zero");
    chk("divu_zero const", last_res, 64'h00000064_FFFFFFFF);
    do_op(MULDIV_DIV, 32'hFFFFFF9C, 32'd0, "div_zero_neg");

    // NCARE start must not launch anything
    prev  = {hi, lo};
    start = 1'b1;
    funct = MULDIV_NCARE;
    a     = 32'd9;
    b     = 32'd9;
    dn    = 0;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) chk("ncare busy", {63'd0, busy}, 64'd0);
      if (done === 1'b1) dn++;
    end
    chk("ncare no_done", 64'(dn), 64'd0);
    chk("ncare hilo", {hi, lo}, prev);

    // flush in cycle 10 of a DIVU, restart in cycle 12
    prev  = {hi, lo};
    start = 1'b1;
    funct = MULDIV_DIVU;
    a     = 32'd1000;
    b     = 32'd7;
    dn    = 0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) dn++;
      if (c == 9) chk("flush busy_before", {63'd0, busy}, 64'd1);
      if (c == 10) flush = 1'b1;
      if (c == 11) begin
        chk("flush busy_after", {63'd0, busy}, 64'd0);
        flush = 1'b0;
      end
    end
    chk("flush no_done", 64'(dn), 64'd0);
    chk("flush hilo", {hi, lo}, prev);
    @(negedge clk);
    do_op(MULDIV_DIVU, 32'd5000, 32'd13, "after_flush");

    // flush and start together: start dropped
    prev  = {hi, lo};
    flush = 1'b1;
    start = 1'b1;
    funct = MULDIV_MULT;
    a     = 32'd3;
    b     = 32'd4;
    dn    = 0;
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    chk("flush_start busy", {63'd0, busy}, 64'd0);
    repeat (36) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    chk("flush_start no_done", 64'(dn), 64'd0);
    chk("flush_start hilo", {hi, lo}, prev);

    // second start in cycle 5 ignored
    start = 1'b1;
    funct = MULDIV_MULT;
    a     = 32'hFFFF1234;
    b     = 32'h00007777;
    dn    = 0;
    lat   = 0;
    res   = 64'd0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 5) begin
        start = 1'b1;
        funct = MULDIV_MULTU;
        a     = 32'd9;
        b     = 32'd9;
      end
      if (done === 1'b1) begin
        dn++;
        if (lat == 0) begin
          lat = c;
          res = {hi, lo};
        end
      end
    end
    chk("restart done_count", 64'(dn), 64'd1);
    chk("restart latency", 64'(lat), 64'd34);
    chk("restart result", res, model(MULDIV_MULT, 32'hFFFF1234, 32'h00007777));

    // reset and flush together: reset wins (hi/lo cleared)
    start = 1'b1;
    funct = MULDIV_MULTU;
    a     = 32'd7;
    b     = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    flush = 1'b0;
    chk("reset_flush hilo", {hi, lo}, 64'd0);
    chk("reset_flush busy", {63'd0, busy}, 64'd0);

    // reset in cycle 20 of a MULT
    do_op(MULDIV_MULTU, 32'd123, 32'd456, "pre_reset");
    start = 1'b1;
    funct = MULDIV_MULT;
    a     = 32'h12345678;
    b     = 32'hFEDCBA98;
    dn    = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 20) reset = 1'b1;
      if (c == 21) begin
        chk("midreset busy_done", {62'd0, busy, done}, 64'd0);
        chk("midreset hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
      end
      if (done === 1'b1) dn++;
    end
    chk("midreset no_done", 64'(dn), 64'd0);

    // random operations against the model
    for (int i = 0; i < 30; i++) begin
      do_op(muldiv_funct_t'($urandom_range(0, 3)), rnd_opnd(), rnd_opnd(), $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
